counter_bcd: RTL and testbench

//   Free-running synchronous decimal counter with packed BCD output. It counts
//   00, 01, ..., 99, then wraps to 00, advancing once per clock.
//   The default build has two digits: a tens digit and a units digit.

---
 rtl/counter_bcd.sv | 53 +++++
 tb/tb_counter_bcd.sv | 125 ++++++++++++
 2 files changed

// File: rtl/counter_bcd.sv
// Free-running packed-BCD counter with NUM_DIGITS decimal digits.
// Counts 0 .. 10^NUM_DIGITS-1 and wraps; synchronous active-high reset.
module counter_bcd #(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [4*NUM_DIGITS-1:0] out
);

    // Advance one BCD digit. Returns {carry_out, next_digit}.
    // Codes >= 9 roll to 0 so that a corrupted A-F digit recovers on its next carry.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic carry_in);
        logic [4:0] result;
        if (!carry_in) begin
            result = {1'b0, digit};
        end else if (digit >= 4'd9) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

    logic [4*NUM_DIGITS-1:0] count_r;
    logic [4*NUM_DIGITS-1:0] count_next_s;

    // Ripple the increment from the units digit upward.
    always_comb begin
        logic       carry_v;
        logic [4:0] step_v;
        count_next_s = {NUM_DIGITS{4'd0}};
        carry_v      = 1'b1;
        step_v       = 5'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step_v                  = bcd_step(count_r[4*i +: 4], carry_v);
            count_next_s[4*i +: 4]  = step_v[3:0];
            carry_v                 = step_v[4];
        end
    end

    // Count register; reset takes priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {NUM_DIGITS{4'd0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign out = count_r;

endmodule

// File: tb/tb_counter_bcd.sv
// Scoreboard bench for counter_bcd: driver queues expected values per edge,
// a negedge monitor pops and compares them against out.
module tb_counter_bcd;

    logic       clk;
    logic       reset;
    logic [7:0] out;

    int checks;
    int errors;
    int model_cnt;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb_q[$];

    counter_bcd #(.NUM_DIGITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'((v / 10) % 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

    // Drive reset for one edge, then queue the value out must hold after it.
    task automatic cycle(input logic r, input logic [7:0] e, input string nm);
        sb_item_t it;
        reset = r;
        @(posedge clk);
        it.exp  = e;
        it.name = nm;
        sb_q.push_back(it);
        model_cnt = r ? 0 : (model_cnt + 1) % 100;
        #1;
    endtask

    task automatic run_model(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, to_bcd((model_cnt + 1) % 100), nm);
        end
    endtask

    // Monitor: pop one expectation per edge and check value and digit legality.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            checks++;
            if (out !== it.exp) begin
                errors++;
                $display("FAIL %s: out=%h expected=%h at t=%0t", it.name, out, it.exp, $time);
            end
            checks++;
            if ((out[3:0] > 4'd9) || (out[7:4] > 4'd9)) begin
                errors++;
                $display("FAIL bcd_legal: out=%h has a nibble above 9 at t=%0t", out, $time);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        reset     = 1'b1;

        // Power-up reset, release, first count
        cycle(1'b1, 8'h00, "powerup_reset");
        cycle(1'b0, 8'h01, "first_count");

        // Walk to the wrap, with hand-computed landmarks
        run_model(7, "count_up");
        cycle(1'b0, 8'h09, "reach_09");
        cycle(1'b0, 8'h10, "carry_09_10");
        run_model(8, "count_up");
        cycle(1'b0, 8'h19, "reach_19");
        cycle(1'b0, 8'h20, "carry_19_20");
        run_model(78, "count_up");
        cycle(1'b0, 8'h99, "edge99_is_99");
        cycle(1'b0, 8'h00, "edge100_wrap");
        cycle(1'b0, 8'h01, "edge101_is_01");

        // Mid-count reset at 47
        run_model(45, "count_up");
        cycle(1'b0, 8'h47, "reach_47");
        cycle(1'b1, 8'h00, "midcount_reset");
        cycle(1'b0, 8'h01, "after_mid_01");
        cycle(1'b0, 8'h02, "after_mid_02");
        cycle(1'b0, 8'h03, "after_mid_03");

        // Held reset for 5 cycles
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h00, "held_reset");
        end
        cycle(1'b0, 8'h01, "after_held_01");

        // Free run across another wrap
        run_model(100, "free_run");
        cycle(1'b0, 8'h02, "free_run_end");

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
